// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the custom CPU instruction and data channels.
// A word-addressed RAM answers fetches and loads after LAT extra wait cycles.
// Stores write byte lanes at the accept edge. The block also counts accepted
// fetches, loads and stores.
//
// state | meaning
// IDLE  | ready for a new fetch or data request (data has priority)
// WAIT  | counting down LAT cycles before presenting a fetch/load response
// IRESP | Instruction valid, held until Inst_Ready
// DRESP | Read_data valid, held until Read_data_Ready
// WBUSY | store absorbed, stalls new requests for LAT cycles
module cpu_mem_responder #(
   parameter int ADDR_W    = 12,
   parameter int LAT       = 2,
   parameter     INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC,
   input  logic        Inst_Req_Valid,
   output logic        Inst_Req_Ready,
   output logic [31:0] Instruction,
   output logic        Inst_Valid,
   input  logic        Inst_Ready,
   input  logic [31:0] Address,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Write_data,
   input  logic [3:0]  Write_strb,
   output logic        Mem_Req_Ready,
   output logic [31:0] Read_data,
   output logic        Read_data_Valid,
   input  logic        Read_data_Ready,
   output logic [31:0] inst_cnt,
   output logic [31:0] load_cnt,
   output logic [31:0] store_cnt
);

   typedef enum logic [2:0] {IDLE, WAIT, IRESP, DRESP, WBUSY} state_t;

   localparam logic [7:0] LAT_C    = 8'(LAT);
   localparam bit         LAT_ZERO = (LAT == 0);

   logic [31:0] mem [0:(1 << ADDR_W) - 1];

   state_t      state, state_d;
   logic [7:0]  cnt, cnt_d;
   logic        tgt_data, tgt_data_d;
   logic [31:0] hold, hold_d;
   logic        fetch_acc, load_acc, store_acc;

   logic [ADDR_W-1:0] i_idx, d_idx;
   assign i_idx = PC[ADDR_W+1:2];
   assign d_idx = Address[ADDR_W+1:2];

   // Address bits above the RAM and the byte offset are intentionally dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{PC[31:ADDR_W+2], PC[1:0], Address[31:ADDR_W+2], Address[1:0]};

   assign Mem_Req_Ready   = (state == IDLE);
   assign Inst_Req_Ready  = (state == IDLE) & ~MemRead & ~MemWrite;
   assign Inst_Valid      = (state == IRESP);
   assign Read_data_Valid = (state == DRESP);

   // Next-state, countdown and holding-register selection.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      tgt_data_d = tgt_data;
      hold_d     = hold;
      fetch_acc  = 1'b0;
      load_acc   = 1'b0;
      store_acc  = 1'b0;
      case (state)
         IDLE: begin
            if (MemWrite) begin
               store_acc = 1'b1;
               cnt_d     = LAT_C;
               state_d   = LAT_ZERO ? IDLE : WBUSY;
            end else if (MemRead) begin
               load_acc   = 1'b1;
               hold_d     = mem[d_idx];
               tgt_data_d = 1'b1;
               cnt_d      = LAT_C;
               state_d    = LAT_ZERO ? DRESP : WAIT;
            end else if (Inst_Req_Valid) begin
               fetch_acc  = 1'b1;
               hold_d     = mem[i_idx];
               tgt_data_d = 1'b0;
               cnt_d      = LAT_C;
               state_d    = LAT_ZERO ? IRESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt - 8'd1;
            if (cnt == 8'd1) state_d = tgt_data ? DRESP : IRESP;
         end
         IRESP: if (Inst_Ready) state_d = IDLE;
         DRESP: if (Read_data_Ready) state_d = IDLE;
         WBUSY: begin
            cnt_d = cnt - 8'd1;
            if (cnt == 8'd1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, response registers and request counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         tgt_data    <= 1'b0;
         hold        <= 32'd0;
         Instruction <= 32'd0;
         Read_data   <= 32'd0;
         inst_cnt    <= 32'd0;
         load_cnt    <= 32'd0;
         store_cnt   <= 32'd0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         tgt_data <= tgt_data_d;
         hold     <= hold_d;
         // Response outputs only change when a response is first presented.
         if (state_d == IRESP && state != IRESP) Instruction <= hold_d;
         if (state_d == DRESP && state != DRESP) Read_data <= hold_d;
         if (fetch_acc) inst_cnt  <= inst_cnt + 32'd1;
         if (load_acc)  load_cnt  <= load_cnt + 32'd1;
         if (store_acc) store_cnt <= store_cnt + 32'd1;
      end
   end

   // Byte-lane store at the accept edge; RAM is never cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst && store_acc) begin
         for (int i = 0; i < 4; i++) begin
            if (Write_strb[i]) mem[d_idx][8*i +: 8] <= Write_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: one instance at LAT=2, one at LAT=0.
module tb_cpu_mem_responder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] a_pc = '0, a_addr = '0, a_wdata = '0;
   logic        a_ireq_v = 0, a_iready = 0, a_mrd = 0, a_mwr = 0, a_rready = 0;
   logic [3:0]  a_wstrb = '0;
   logic        a_ireq_r, a_ivalid, a_mreq_r, a_rvalid;
   logic [31:0] a_inst, a_rdata, a_icnt, a_lcnt, a_scnt;

   logic [31:0] b_pc = '0, b_addr = '0, b_wdata = '0;
   logic        b_ireq_v = 0, b_iready = 0, b_mrd = 0, b_mwr = 0, b_rready = 0;
   logic [3:0]  b_wstrb = '0;
   logic        b_ireq_r, b_ivalid, b_mreq_r, b_rvalid;
   logic [31:0] b_inst, b_rdata, b_icnt, b_lcnt, b_scnt;

   cpu_mem_responder #(.ADDR_W(12), .LAT(2)) dut_a (
      .clk(clk), .rst(rst), .PC(a_pc), .Inst_Req_Valid(a_ireq_v), .Inst_Req_Ready(a_ireq_r),
      .Instruction(a_inst), .Inst_Valid(a_ivalid), .Inst_Ready(a_iready), .Address(a_addr),
      .MemRead(a_mrd), .MemWrite(a_mwr), .Write_data(a_wdata), .Write_strb(a_wstrb),
      .Mem_Req_Ready(a_mreq_r), .Read_data(a_rdata), .Read_data_Valid(a_rvalid),
      .Read_data_Ready(a_rready), .inst_cnt(a_icnt), .load_cnt(a_lcnt), .store_cnt(a_scnt));

   cpu_mem_responder #(.ADDR_W(12), .LAT(0)) dut_b (
      .clk(clk), .rst(rst), .PC(b_pc), .Inst_Req_Valid(b_ireq_v), .Inst_Req_Ready(b_ireq_r),
      .Instruction(b_inst), .Inst_Valid(b_ivalid), .Inst_Ready(b_iready), .Address(b_addr),
      .MemRead(b_mrd), .MemWrite(b_mwr), .Write_data(b_wdata), .Write_strb(b_wstrb),
      .Mem_Req_Ready(b_mreq_r), .Read_data(b_rdata), .Read_data_Valid(b_rvalid),
      .Read_data_Ready(b_rready), .inst_cnt(b_icnt), .load_cnt(b_lcnt), .store_cnt(b_scnt));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_wait_idle();
      int n = 0;
      while (!a_mreq_r && n < 20) begin tick(); n++; end
      check("a_idle_timeout", {31'd0, a_mreq_r}, 32'd1);
   endtask

   task automatic a_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      a_addr = addr; a_wdata = data; a_wstrb = strb; a_mwr = 1'b1;
      tick();
      a_mwr = 1'b0;
      a_wait_idle();
   endtask

   task automatic a_load(input logic [31:0] addr, output logic [31:0] data);
      int n = 0;
      a_addr = addr; a_mrd = 1'b1;
      tick();
      a_mrd = 1'b0;
      while (!a_rvalid && n < 20) begin tick(); n++; end
      check("a_load_latency", n, 32'd2);
      data = a_rdata;
      a_rready = 1'b1;
      tick();
      a_rready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d, snap;
      int n;

      // Reset state
      tick(); tick();
      rst = 1'b0;
      check("rst_ireq_ready", {31'd0, a_ireq_r}, 32'd1);
      check("rst_mreq_ready", {31'd0, a_mreq_r}, 32'd1);
      check("rst_ivalid",     {31'd0, a_ivalid}, 32'd0);
      check("rst_rvalid",     {31'd0, a_rvalid}, 32'd0);
      check("rst_inst",       a_inst,  32'd0);
      check("rst_rdata",      a_rdata, 32'd0);
      check("rst_cnts",       a_icnt | a_lcnt | a_scnt, 32'd0);

      // LAT=0: partial byte store then full-word load sees merged lanes
      b_addr = 32'h20; b_wdata = 32'h11223344; b_wstrb = 4'hF; b_mwr = 1'b1;
      tick();
      b_mwr = 1'b0;
      check("b_store_noidle", {31'd0, b_mreq_r}, 32'd1);
      b_addr = 32'h23; b_wdata = 32'hAB000000; b_wstrb = 4'b1000; b_mwr = 1'b1;
      tick();
      b_mwr = 1'b0;
      b_addr = 32'h20; b_mrd = 1'b1;
      tick();
      b_mrd = 1'b0;
      check("b_rvalid_lat0", {31'd0, b_rvalid}, 32'd1);
      check("b_byte_merge",  b_rdata, 32'hAB223344);
      b_rready = 1'b1;
      tick();
      b_rready = 1'b0;
      check("b_rvalid_drop", {31'd0, b_rvalid}, 32'd0);
      check("b_store_cnt",   b_scnt, 32'd2);
      check("b_load_cnt",    b_lcnt, 32'd1);

      // LAT=2 fetch: valid 3 cycles after accept, then 5-cycle stall
      a_store(32'h10, 32'h00500093, 4'hF);
      a_pc = 32'h10; a_ireq_v = 1'b1;
      #1;
      check("fetch_ready", {31'd0, a_ireq_r}, 32'd1);
      tick();
      a_ireq_v = 1'b0;
      check("fetch_c1_valid", {31'd0, a_ivalid}, 32'd0);
      check("fetch_icnt",     a_icnt, 32'd1);
      tick();
      check("fetch_c2_valid", {31'd0, a_ivalid}, 32'd0);
      tick();
      check("fetch_c3_valid", {31'd0, a_ivalid}, 32'd1);
      check("fetch_inst",     a_inst, 32'h00500093);
      a_ireq_v = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", {31'd0, a_ivalid}, 32'd1);
         check("stall_inst",  a_inst, 32'h00500093);
         check("stall_ireq",  {31'd0, a_ireq_r}, 32'd0);
      end
      a_ireq_v = 1'b0; a_iready = 1'b1;
      tick();
      a_iready = 1'b0;
      check("fetch_done_valid", {31'd0, a_ivalid}, 32'd0);
      check("fetch_done_icnt",  a_icnt, 32'd1);
      check("inst_kept",        a_inst, 32'h00500093);

      // Aliasing: 0x4000_0008 maps to the same word as 0x8
      a_store(32'h8, 32'hCAFEF00D, 4'hF);
      a_load(32'h40000008, d);
      check("alias_load", d, 32'hCAFEF00D);
      a_load(32'h8, d);
      check("direct_load", d, 32'hCAFEF00D);

      // Simultaneous fetch and load: load first, fetch after DRESP handshake
      a_pc = 32'h10; a_ireq_v = 1'b1; a_addr = 32'h8; a_mrd = 1'b1;
      #1;
      check("prio_ireq_ready", {31'd0, a_ireq_r}, 32'd0);
      check("prio_mreq_ready", {31'd0, a_mreq_r}, 32'd1);
      tick();
      a_mrd = 1'b0;
      check("prio_lcnt", a_lcnt, 32'd3);
      check("prio_icnt", a_icnt, 32'd1);
      n = 0;
      while (!a_rvalid && n < 20) begin tick(); n++; end
      check("prio_rvalid", {31'd0, a_rvalid}, 32'd1);
      check("prio_rdata",  a_rdata, 32'hCAFEF00D);
      check("prio_no_ivalid", {31'd0, a_ivalid}, 32'd0);
      a_rready = 1'b1;
      tick();
      a_rready = 1'b0;
      check("prio_fetch_ready", {31'd0, a_ireq_r}, 32'd1);
      tick();
      a_ireq_v = 1'b0;
      check("prio_fetch_icnt", a_icnt, 32'd2);
      n = 0;
      while (!a_ivalid && n < 20) begin tick(); n++; end
      check("prio_fetch_inst", a_inst, 32'h00500093);
      a_iready = 1'b1;
      tick();
      a_iready = 1'b0;

      // Zero strobe writes nothing but counts
      a_store(32'h8, 32'hFFFFFFFF, 4'h0);
      check("strb0_scnt", a_scnt, 32'd3);
      a_load(32'h8, d);
      check("strb0_data", d, 32'hCAFEF00D);

      // MemRead and MemWrite together: store only, then RAW
      a_addr = 32'h8; a_wdata = 32'h12345678; a_wstrb = 4'hF; a_mrd = 1'b1; a_mwr = 1'b1;
      tick();
      a_mrd = 1'b0; a_mwr = 1'b0;
      snap = a_lcnt;
      check("rw_scnt", a_scnt, 32'd4);
      check("rw_lcnt", snap, 32'd4);
      tick(); tick();
      check("rw_no_rvalid", {31'd0, a_rvalid}, 32'd0);
      check("rw_idle", {31'd0, a_mreq_r}, 32'd1);
      a_load(32'h8, d);
      check("raw_data", d, 32'h12345678);

      // Reset while a load waits: response dropped, RAM kept
      a_addr = 32'h8; a_mrd = 1'b1;
      tick();
      a_mrd = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_idle",   {31'd0, a_mreq_r}, 32'd1);
      check("mrst_rvalid", {31'd0, a_rvalid}, 32'd0);
      check("mrst_cnts",   a_icnt | a_lcnt | a_scnt, 32'd0);
      check("mrst_rdata",  a_rdata, 32'd0);
      tick(); tick(); tick();
      check("mrst_no_late_rvalid", {31'd0, a_rvalid}, 32'd0);
      a_load(32'h8, d);
      check("mrst_ram_kept", d, 32'h12345678);
      check("mrst_lcnt", a_lcnt, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
